// File: rtl/data_sender_pkg.sv
// Shared types and defaults for the req/ack CDC handshake pair (sender and receiver).
package data_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_ACK_LO = 2'd2
  } state_e;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // States in which the sender is waiting on the far side's ack.
  function automatic logic is_ack_wait(state_e s);
    return (s == ST_REQ_HI) || (s == ST_ACK_LO);
  endfunction

endpackage

// File: rtl/data_sender_if.sv
// Local producer handshake into the domain-A sender.
// valid/ready: a word moves on any clock edge where valid && ready are both high;
// data is only looked at on that edge, and valid may be held high across several words.
interface data_sender_if #(
  parameter int DATA_W = 4
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer, async active-low reset to 0.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/data_sender.sv
// Domain-A source of a 4-phase req/ack multi-bit CDC handshake, with ack-wait
// timeout flag and completed-transfer counter.
module data_sender
  import data_sender_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 8
) (
  input  logic              i_clk_a,
  input  logic              i_rst_n,
  data_sender_if.slave      prod,
  output logic              o_data_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ack,
  output logic              o_busy,
  output logic              o_timeout,
  input  logic              i_err_clr,
  output logic [CNT_W-1:0]  o_xfer_cnt,
  output state_e            o_dbg_state
);

  // Counter saturates one above the trip value so the flag sets exactly once per wait.
  localparam int WAIT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ack_s;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .i_clk   (i_clk_a),
    .i_rst_n (i_rst_n),
    .i_d     (i_data_ack),
    .o_q     (ack_s)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    wait_d    = wait_q;
    if (wait_q != WAIT_W'(TIMEOUT_CYC)) begin
      wait_d = wait_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (prod.valid) begin
          data_d  = prod.data;
          req_d   = 1'b1;
          wait_d  = '0;
          state_d = ST_REQ_HI;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          wait_d  = '0;
          state_d = ST_ACK_LO;
        end
      end
      ST_ACK_LO: begin
        if (!ack_s) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A set landing on the same edge as a clear wins.
    if (i_err_clr) begin
      timeout_d = 1'b0;
    end
    if ((TIMEOUT_CYC > 0) && is_ack_wait(state_q) &&
        (wait_q == WAIT_W'(TIMEOUT_CYC - 1))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk_a or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign prod.ready  = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_data_req  = req_q;
  assign o_data      = data_q;
  assign o_timeout   = timeout_q;
  assign o_xfer_cnt  = cnt_q;
  assign o_dbg_state = state_q;

  // A still-high ack when a new word is taken means the receiver broke the 4-phase order.
  a_no_stale_ack: assert property (@(posedge i_clk_a) disable iff (!i_rst_n)
    (state_q == ST_IDLE && prod.valid) |-> !ack_s);

endmodule
